// File: rtl/data_path_param.sv
// rtl/data_path_param.sv - parameterised load/store datapath: IR, decode, 4-entry register file, ALU, flags, PC
package k_and_s_pkg;
    typedef enum logic [3:0] {
        I_NOP,
        I_BRANCH,
        I_BZERO,
        I_BNEG,
        I_BNNEG,
        I_BNZERO,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_HALT
    } decoded_instruction_type;
endpackage

module data_path_param
    import k_and_s_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter bit SAT_MODE = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    branch,
    input  logic                    pc_enable,
    input  logic                    ir_enable,
    input  logic                    addr_sel,
    input  logic                    c_sel,
    input  logic                    write_reg_enable,
    input  logic                    flags_reg_enable,
    input  logic [1:0]              operation,
    input  logic [DATA_W-1:0]       data_in,
    output decoded_instruction_type decoded_instruction,
    output logic                    zero_op,
    output logic                    neg_op,
    output logic                    unsigned_overflow,
    output logic                    signed_overflow,
    output logic [4:0]              ram_addr,
    output logic [DATA_W-1:0]       data_out
);

    localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [15:0]       ir;
    logic [4:0]        pc;
    logic [DATA_W-1:0] regs [4];

    logic [1:0]        a_addr;
    logic [1:0]        b_addr;
    logic [1:0]        c_addr;
    logic [4:0]        mem_addr;

    logic [DATA_W-1:0] bus_a;
    logic [DATA_W-1:0] bus_b;
    logic [DATA_W-1:0] bus_c;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [DATA_W-1:0] alu_raw;
    logic [DATA_W-1:0] alu_result;
    logic              alu_uovf;
    logic              alu_sovf;

    logic              unused_ir_bit;
    assign unused_ir_bit = ir[7];

    always_comb begin
        decoded_instruction = I_NOP;
        a_addr   = 2'd0;
        b_addr   = 2'd0;
        c_addr   = 2'd0;
        mem_addr = 5'd0;
        case (ir[15:8])
            8'h01: begin decoded_instruction = I_BRANCH; mem_addr = ir[4:0]; end
            8'h02: begin decoded_instruction = I_BZERO;  mem_addr = ir[4:0]; end
            8'h03: begin decoded_instruction = I_BNEG;   mem_addr = ir[4:0]; end
            8'h0A: begin decoded_instruction = I_BNNEG;  mem_addr = ir[4:0]; end
            8'h0B: begin decoded_instruction = I_BNZERO; mem_addr = ir[4:0]; end
            8'h81: begin decoded_instruction = I_LOAD;  c_addr = ir[6:5]; mem_addr = ir[4:0]; end
            8'h82: begin decoded_instruction = I_STORE; a_addr = ir[6:5]; mem_addr = ir[4:0]; end
            8'h91: begin
                decoded_instruction = I_MOVE;
                a_addr = ir[1:0];
                b_addr = ir[1:0];
                c_addr = ir[3:2];
            end
            8'hA1, 8'hA2, 8'hA3, 8'hA4: begin
                case (ir[9:8])
                    2'b01:   decoded_instruction = I_ADD;
                    2'b10:   decoded_instruction = I_SUB;
                    2'b11:   decoded_instruction = I_AND;
                    default: decoded_instruction = I_OR;
                endcase
                a_addr = ir[1:0];
                b_addr = ir[3:2];
                c_addr = ir[5:4];
            end
            8'hFF:   decoded_instruction = I_HALT;
            default: decoded_instruction = I_NOP;
        endcase
    end

    assign bus_a    = regs[a_addr];
    assign bus_b    = regs[b_addr];
    assign data_out = bus_a;

    assign sum_ext  = {1'b0, bus_a} + {1'b0, bus_b};
    assign diff_ext = {1'b0, bus_a} - {1'b0, bus_b};

    // Overflow direction always follows operand a's sign, for ADD and SUB alike.
    always_comb begin
        alu_raw  = '0;
        alu_uovf = 1'b0;
        alu_sovf = 1'b0;
        case (operation)
            2'b00: alu_raw = bus_a | bus_b;
            2'b01: begin
                alu_raw  = sum_ext[DATA_W-1:0];
                alu_uovf = sum_ext[DATA_W];
                alu_sovf = (bus_a[DATA_W-1] == bus_b[DATA_W-1]) &&
                           (sum_ext[DATA_W-1] != bus_a[DATA_W-1]);
            end
            2'b10: begin
                alu_raw  = diff_ext[DATA_W-1:0];
                alu_uovf = diff_ext[DATA_W];
                alu_sovf = (bus_a[DATA_W-1] != bus_b[DATA_W-1]) &&
                           (diff_ext[DATA_W-1] != bus_a[DATA_W-1]);
            end
            default: alu_raw = bus_a & bus_b;
        endcase
        alu_result = alu_raw;
        if (SAT_MODE && alu_sovf) begin
            alu_result = bus_a[DATA_W-1] ? SAT_MIN : SAT_MAX;
        end
    end

    assign bus_c    = c_sel ? data_in : alu_result;
    assign ram_addr = addr_sel ? pc : mem_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= 16'd0;
        end else if (ir_enable) begin
            ir <= data_in[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= 5'd0;
        end else if (pc_enable) begin
            pc <= branch ? mem_addr : pc + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else if (write_reg_enable) begin
            regs[c_addr] <= bus_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_op           <= 1'b0;
            neg_op            <= 1'b0;
            unsigned_overflow <= 1'b0;
            signed_overflow   <= 1'b0;
        end else if (flags_reg_enable) begin
            zero_op           <= (alu_result == '0);
            neg_op            <= alu_result[DATA_W-1];
            unsigned_overflow <= alu_uovf;
            signed_overflow   <= alu_sovf;
        end
    end

endmodule

// File: doc/data_path_param.md
DATA_PATH_PARAM -- requirements
Module: data_path_param

Interface
REQ-001 DATA_W, 16, data/register width; legal 16..32; instruction is always data_in[15:0].
REQ-002 SAT_MODE, 0, 0 = wrapping ADD/SUB; 1 = signed-saturating ADD/SUB.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 branch, pc_enable, ir_enable, addr_sel, c_sel, write_reg_enable, flags_reg_enable  in  1 each  control strobes from the control unit.
REQ-006 operation  in  2  ALU select: 00 OR, 01 ADD, 10 SUB, 11 AND.
REQ-007 data_in  in  DATA_W  memory read data.
REQ-008 decoded_instruction  out  decoded_instruction_type (k_and_s_pkg)  decode of IR.
REQ-009 zero_op, neg_op, unsigned_overflow, signed_overflow  out  1 each  registered flags.
REQ-010 ram_addr  out  5  memory address; data_out  out  DATA_W  store data.

Function
REQ-011 IR (16 b) SHALL load data_in[15:0] on a clock edge with ir_enable=1, else hold.
REQ-012 Decode of IR[15:8], combinational: 0x00 NOP, 0x01 BRANCH, 0x02 BZERO, 0x03 BNEG, 0x0A BNNEG, 0x0B BNZERO, 0x81 LOAD, 0x82 STORE, 0x91 MOVE, 0xA1 ADD, 0xA2 SUB, 0xA3 AND, 0xA4 OR, 0xFF HALT; any other value SHALL decode as I_NOP.
REQ-013 Fields: LOAD c=IR[6:5], mem_addr=IR[4:0]; STORE a=IR[6:5], mem_addr=IR[4:0]; MOVE a=b=IR[1:0], c=IR[3:2]; ALU ops a=IR[1:0], b=IR[3:2], c=IR[5:4]; branches mem_addr=IR[4:0]; fields unused by an opcode SHALL be 0.
REQ-014 Register file: 4 x DATA_W; bus_a=R[a], bus_b=R[b] read combinationally; data_out SHALL equal bus_a combinationally.
REQ-015 bus_c SHALL be data_in when c_sel=1, else ALU result; R[c] SHALL load bus_c on an edge with write_reg_enable=1; no other register changes.
REQ-016 Write and read of the same register in one cycle: buses SHALL show the old value until the edge.
REQ-017 ALU SHALL be combinational, DATA_W bits; ADD/SUB modulo 2^DATA_W when SAT_MODE=0.
REQ-018 SAT_MODE=1: on signed overflow, ADD/SUB result SHALL clamp to 2^(DATA_W-1)-1 (positive overflow) or -2^(DATA_W-1) (negative overflow); OR/AND unaffected.
REQ-019 Flag sources: zero = final result==0; neg = final result MSB; unsigned_ovf = carry-out (ADD) or borrow, a<b unsigned (SUB); signed_ovf = operand signs equal and raw-sum sign differs (ADD), operand signs differ and raw-result sign differs from a (SUB); both overflow sources 0 for OR/AND.
REQ-020 Flag registers SHALL load all four sources on an edge with flags_reg_enable=1 and hold otherwise.
REQ-021 PC (5 b): on edge with pc_enable=1, PC SHALL become mem_addr if branch=1, else PC+1 wrapping 31->0; hold when pc_enable=0.
REQ-022 ram_addr SHALL be PC when addr_sel=1, else mem_addr, combinational.
REQ-023 ir_enable and pc_enable asserted together SHALL both update; branch target uses the pre-edge IR.

Reset
REQ-024 rst_n=0 SHALL immediately clear IR, PC, R0..R3 and all four flags to 0, regardless of clock or strobes.
REQ-025 Post-reset outputs: decoded_instruction=I_NOP, ram_addr=0 when addr_sel=1, data_out=0, flags 0.
REQ-026 Reset asserted mid-instruction SHALL abort it; no pending write or flag update survives reset.

Verification
REQ-027 Fetch: addr_sel=1, data_in=0x8123, ir_enable+pc_enable one cycle from reset -> decoded I_LOAD, c=1, ram_addr (addr_sel=0)=0x03, PC=1.
REQ-028 Load/ADD: load R1=0x7FFF, R2=0x0001, ADD R3=R1+R2 (IR 0xA136), flags_reg_enable -> SAT_MODE=0: R3=0x8000, neg=1, signed_ovf=1, unsigned_ovf=0; SAT_MODE=1: R3=0x7FFF, neg=0, signed_ovf=1.
REQ-029 SUB borrow: R0=0x0000, R1=0x0001, SUB R2=R0-R1 (IR 0xA224) -> R2=0xFFFF, unsigned_ovf=1, signed_ovf=0, zero=0; flags hold next cycle with flags_reg_enable=0.
REQ-030 Branch/wrap: PC=31, pc_enable=1, branch=0 -> PC=0; IR=0x0114, branch=1, pc_enable=1 -> PC=0x14.
REQ-031 Unknown opcode 0x55 -> I_NOP, all fields 0; STORE IR 0x8245 with R2=0xBEEF -> data_out=0xBEEF, ram_addr=0x05.
REQ-032 Async reset: rst_n low between edges after REQ-028 -> R3, PC, flags read 0 before next edge; DATA_W=32 rerun of REQ-028 -> R3=0x00008000, no overflow.
